ram_port_arbiter: RTL and testbench

Two-requester round-robin arbiter that time-shares one single-port 64x8 RAM port (data/addr/we in, q out, asynchronous read).
Each requester issues one read or write per req/gnt handshake. The arbiter registers the winning request onto the RAM port, then returns read data with a valid pulse.
It sits between two client blocks and the RAM instance. It is the only driver of the RAM's data/addr/we.

---
 rtl/ram_port_arbiter_if.sv | 24 ++
 rtl/ram_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Requester-side handshake bundle for ram_port_arbiter: one request/grant
// port carrying a single read or write per handshake.
interface ram_port_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter time-sharing one single-port asynchronous-read RAM.
// Define ARB_FIXED_PRIO_EN for fixed A-over-B priority; default is round-robin.
module ram_port_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_port_arbiter_if.slave a_if,
    ram_port_arbiter_if.slave b_if,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              ram_we_o,
    input  logic [DATA_W-1:0] ram_q_i
);

`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;
    typedef enum logic {SEL_A = 1'b0, SEL_B = 1'b1} sel_t;

    state_t            state_q, state_d;
    sel_t              last_q, last_d;
    sel_t              win_q, win_d;
    sel_t              pick;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              we_q, we_d;
    logic              a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
    logic              a_rv_q, a_rv_d, b_rv_q, b_rv_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        pick = SEL_A;
        if (a_if.req && b_if.req) begin
            pick = (FIXED_PRIO || last_q == SEL_B) ? SEL_A : SEL_B;
        end else if (b_if.req) begin
            pick = SEL_B;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        win_d     = win_q;
        rd_d      = rd_q;
        addr_d    = addr_q;
        data_d    = data_q;
        we_d      = 1'b0;
        a_gnt_d   = 1'b0;
        b_gnt_d   = 1'b0;
        a_rv_d    = 1'b0;
        b_rv_d    = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        case (state_q)
            IDLE: begin
                if (a_if.req || b_if.req) begin
                    state_d = ACCESS;
                    win_d   = pick;
                    last_d  = pick;
                    if (pick == SEL_A) begin
                        addr_d  = a_if.addr;
                        data_d  = a_if.wdata;
                        we_d    = a_if.we;
                        rd_d    = !a_if.we;
                        a_gnt_d = 1'b1;
                    end else begin
                        addr_d  = b_if.addr;
                        data_d  = b_if.wdata;
                        we_d    = b_if.we;
                        rd_d    = !b_if.we;
                        b_gnt_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // Requests are ignored here; the RAM output is captured for reads.
                state_d = IDLE;
                if (rd_q) begin
                    if (win_q == SEL_A) begin
                        a_rv_d    = 1'b1;
                        a_rdata_d = ram_q_i;
                    end else begin
                        b_rv_d    = 1'b1;
                        b_rdata_d = ram_q_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= SEL_B;
            win_q     <= SEL_A;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            a_gnt_q   <= 1'b0;
            b_gnt_q   <= 1'b0;
            a_rv_q    <= 1'b0;
            b_rv_q    <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            win_q     <= win_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we_q      <= we_d;
            a_gnt_q   <= a_gnt_d;
            b_gnt_q   <= b_gnt_d;
            a_rv_q    <= a_rv_d;
            b_rv_q    <= b_rv_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign ram_addr_o  = addr_q;
    assign ram_data_o  = data_q;
    assign ram_we_o    = we_q;
    assign a_if.gnt    = a_gnt_q;
    assign a_if.rvalid = a_rv_q;
    assign a_if.rdata  = a_rdata_q;
    assign b_if.gnt    = b_gnt_q;
    assign b_if.rvalid = b_rv_q;
    assign b_if.rdata  = b_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level schedule of grants and read returns.
module tb_ram_port_arbiter;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;
`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) a_if ();
    ram_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) b_if ();

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] ram_q;
    logic              ram_we;
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [DATA_W-1:0] pre_data = '0;
    logic [DATA_W-1:0] mem [0:63];

    int checks = 0;
    int errors = 0;

    ram_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_if       (a_if),
        .b_if       (b_if),
        .ram_addr_o (ram_addr),
        .ram_data_o (ram_data),
        .ram_we_o   (ram_we),
        .ram_q_i    (ram_q)
    );

    // RAM with asynchronous read; the side port only preloads while the arbiter is idle.
    assign ram_q = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end

    // Arbitration rule: lone requester wins; on a tie, the one that did not win last.
    function automatic bit pick_b(input bit ra, input bit rb, input bit last_b);
        return (ra && rb) ? (FIXED ? 1'b0 : !last_b) : rb;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_if.req = 1'b0; a_if.we = 1'b0; a_if.addr = '0; a_if.wdata = '0;
        b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = '0; b_if.wdata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic preload(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        pre_addr = addr;
        pre_data = data;
        pre_we   = 1'b1;
        step();
        pre_we   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({a_if.gnt, b_if.gnt, a_if.rvalid, b_if.rvalid, ram_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {a_if.gnt, b_if.gnt, a_if.rvalid, b_if.rvalid, ram_we});
        end
        checks++;
        if ({a_if.rdata, b_if.rdata} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rdata: got %h want 0000", {a_if.rdata, b_if.rdata});
        end
        checks++;
        if ({ram_addr, ram_data} !== 14'h0) begin
            errors++;
            $display("FAIL reset_ram_port: got addr %h data %h want 0 0", ram_addr, ram_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_access();
        apply_reset();
        preload(6'h10, 8'h00);
        a_if.req = 1'b1; a_if.we = 1'b1; a_if.addr = 6'h10; a_if.wdata = 8'h5A;
        step();
        checks++;
        if ({a_if.gnt, ram_we} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_grant: got gnt/we %b want 11", {a_if.gnt, ram_we});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_if.gnt, ram_we} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_async_clear: got gnt/we %b want 00", {a_if.gnt, ram_we});
        end
        a_if.req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if ({a_if.gnt, a_if.rvalid, ram_we} !== 3'b000) begin
                errors++;
                $display("FAIL midrst_quiet[%0d]: got gnt/rvalid/we %b want 000", k,
                         {a_if.gnt, a_if.rvalid, ram_we});
            end
        end
        checks++;
        if (mem[6'h10] !== 8'h00) begin
            errors++;
            $display("FAIL midrst_no_write: got mem %h want 00", mem[6'h10]);
        end
    endtask

    task automatic test_write_read();
        apply_reset();
        a_if.req = 1'b1; a_if.we = 1'b1; a_if.addr = 6'h00; a_if.wdata = 8'hAA;
        step();
        checks++;
        if ({a_if.gnt, b_if.gnt, ram_we, ram_addr, ram_data} !== {3'b101, 6'h00, 8'hAA}) begin
            errors++;
            $display("FAIL wr_grant: got gnt %b%b we %b addr %h data %h want 1 0 1 00 aa",
                     a_if.gnt, b_if.gnt, ram_we, ram_addr, ram_data);
        end
        a_if.req = 1'b0;
        step();
        checks++;
        if ({a_if.gnt, a_if.rvalid, ram_we, b_if.gnt, b_if.rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL wr_after: got %b want 00000",
                     {a_if.gnt, a_if.rvalid, ram_we, b_if.gnt, b_if.rvalid});
        end
        a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 6'h00; a_if.wdata = 8'h00;
        step();
        checks++;
        if ({a_if.gnt, b_if.gnt, ram_we} !== 3'b100) begin
            errors++;
            $display("FAIL rd_grant: got gnt/bgnt/we %b want 100", {a_if.gnt, b_if.gnt, ram_we});
        end
        a_if.req = 1'b0;
        step();
        checks++;
        if ({a_if.rvalid, b_if.rvalid, a_if.rdata} !== {2'b10, 8'hAA}) begin
            errors++;
            $display("FAIL rd_data: got rvalid %b%b rdata %h want 10 aa",
                     a_if.rvalid, b_if.rvalid, a_if.rdata);
        end
        step();
        checks++;
        if ({a_if.rvalid, a_if.rdata} !== {1'b0, 8'hAA}) begin
            errors++;
            $display("FAIL rd_pulse_hold: got rvalid %b rdata %h want 0 aa", a_if.rvalid, a_if.rdata);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        preload(6'h05, 8'h11);
        preload(6'h06, 8'h22);
        a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 6'h05;
        b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 6'h06;
        step();
        checks++;
        if ({a_if.gnt, b_if.gnt} !== 2'b10) begin
            errors++;
            $display("FAIL sim_first: got gnt %b want 10", {a_if.gnt, b_if.gnt});
        end
        a_if.req = 1'b0;
        step();
        checks++;
        if ({a_if.gnt, b_if.gnt, a_if.rvalid, b_if.rvalid, a_if.rdata} !== {4'b0010, 8'h11}) begin
            errors++;
            $display("FAIL sim_a_data: got gnt %b%b rv %b%b rdata %h want 00 10 11",
                     a_if.gnt, b_if.gnt, a_if.rvalid, b_if.rvalid, a_if.rdata);
        end
        step();
        checks++;
        if ({a_if.gnt, b_if.gnt, a_if.rvalid} !== 3'b010) begin
            errors++;
            $display("FAIL sim_second: got gnt %b%b arv %b want 01 0",
                     a_if.gnt, b_if.gnt, a_if.rvalid);
        end
        b_if.req = 1'b0;
        step();
        checks++;
        if ({a_if.rvalid, b_if.rvalid, b_if.rdata} !== {2'b01, 8'h22}) begin
            errors++;
            $display("FAIL sim_b_data: got rv %b%b rdata %h want 01 22",
                     a_if.rvalid, b_if.rvalid, b_if.rdata);
        end
        step();
        checks++;
        if ({a_if.rvalid, b_if.rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL sim_pulse: got rv %b want 00", {a_if.rvalid, b_if.rvalid});
        end
    endtask

    task automatic test_contention();
        bit last_b = 1'b1;
        bit wb = 1'b0;
        apply_reset();
        preload(6'h05, 8'h11);
        preload(6'h06, 8'h22);
        a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 6'h05;
        b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 6'h06;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k % 2 == 1) begin
                wb = pick_b(1'b1, 1'b1, last_b);
                last_b = wb;
                checks++;
                if ({a_if.gnt, b_if.gnt} !== (wb ? 2'b01 : 2'b10)) begin
                    errors++;
                    $display("FAIL cont_gnt[%0d]: got %b want %b", k, {a_if.gnt, b_if.gnt},
                             wb ? 2'b01 : 2'b10);
                end
            end else begin
                checks++;
                if ({a_if.gnt, b_if.gnt, a_if.rvalid, b_if.rvalid} !==
                    (wb ? 4'b0001 : 4'b0010)) begin
                    errors++;
                    $display("FAIL cont_gap[%0d]: got gnt/rv %b want %b", k,
                             {a_if.gnt, b_if.gnt, a_if.rvalid, b_if.rvalid},
                             wb ? 4'b0001 : 4'b0010);
                end
                checks++;
                if ((wb ? b_if.rdata : a_if.rdata) !== (wb ? 8'h22 : 8'h11)) begin
                    errors++;
                    $display("FAIL cont_data[%0d]: got %h want %h", k,
                             wb ? b_if.rdata : a_if.rdata, wb ? 8'h22 : 8'h11);
                end
            end
        end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_hazard();
        apply_reset();
        preload(6'h3F, 8'h00);
        a_if.req = 1'b1; a_if.we = 1'b1; a_if.addr = 6'h3F; a_if.wdata = 8'h3C;
        b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 6'h3F;
        step();
        checks++;
        if ({a_if.gnt, b_if.gnt, ram_we} !== 3'b101) begin
            errors++;
            $display("FAIL haz_a: got gnt/we %b want 101", {a_if.gnt, b_if.gnt, ram_we});
        end
        a_if.req = 1'b0;
        step();
        step();
        checks++;
        if ({a_if.gnt, b_if.gnt, ram_we} !== 3'b010) begin
            errors++;
            $display("FAIL haz_b: got gnt/we %b want 010", {a_if.gnt, b_if.gnt, ram_we});
        end
        b_if.req = 1'b0;
        step();
        checks++;
        if ({b_if.rvalid, b_if.rdata, a_if.rvalid} !== {1'b1, 8'h3C, 1'b0}) begin
            errors++;
            $display("FAIL haz_data: got brv %b rdata %h arv %b want 1 3c 0",
                     b_if.rvalid, b_if.rdata, a_if.rvalid);
        end
        step();
    endtask

`ifdef ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        int na = 0;
        int nb = 0;
        bit seen = 1'b0;
        apply_reset();
        a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 6'h01;
        b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 6'h02;
        for (int k = 1; k <= 8; k++) begin
            step();
            na += int'(a_if.gnt);
            nb += int'(b_if.gnt);
        end
        checks++;
        if (na != 4 || nb != 0) begin
            errors++;
            $display("FAIL fixed_counts: got a %0d b %0d want a 4 b 0", na, nb);
        end
        a_if.req = 1'b0;
        for (int k = 0; k < 2 && !seen; k++) begin
            step();
            seen = b_if.gnt;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL fixed_b_after_drop: got no b_gnt want b_gnt within 2 cycles");
        end
        idle_inputs();
        step();
        step();
    endtask
`endif

    task automatic test_random();
        localparam int N = 400;
        bit ega [N+3];
        bit egb [N+3];
        bit ewe [N+3];
        bit era [N+3];
        bit erb [N+3];
        logic [DATA_W-1:0] eda [N+3];
        logic [DATA_W-1:0] edb [N+3];
        logic [DATA_W-1:0] model [4];
        logic [DATA_W-1:0] hold_a = '0;
        logic [DATA_W-1:0] hold_b = '0;
        int next_free = 0;
        bit last_b = 1'b1;
        bit wb = 1'b0;
        bit was_req = 1'b0;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            model[i] = DATA_W'($urandom);
            preload(ADDR_W'(i), model[i]);
        end
        for (int e = 1; e <= N; e++) begin
            // Schedule what the edge about to be taken must produce.
            if (e >= next_free && (a_if.req || b_if.req)) begin
                wb = pick_b(a_if.req, b_if.req, last_b);
                last_b = wb;
                next_free = e + 2;
                if (!wb) begin
                    ega[e] = 1'b1;
                    ewe[e] = a_if.we;
                    if (a_if.we) model[a_if.addr[1:0]] = a_if.wdata;
                    else begin era[e+1] = 1'b1; eda[e+1] = model[a_if.addr[1:0]]; end
                end else begin
                    egb[e] = 1'b1;
                    ewe[e] = b_if.we;
                    if (b_if.we) model[b_if.addr[1:0]] = b_if.wdata;
                    else begin erb[e+1] = 1'b1; edb[e+1] = model[b_if.addr[1:0]]; end
                end
            end
            step();
            if (era[e]) hold_a = eda[e];
            if (erb[e]) hold_b = edb[e];
            checks++;
            if ({a_if.gnt, b_if.gnt, ram_we} !== {ega[e], egb[e], ewe[e]}) begin
                errors++;
                $display("FAIL rnd_gnt[%0d]: got gnt/we %b want %b", e,
                         {a_if.gnt, b_if.gnt, ram_we}, {ega[e], egb[e], ewe[e]});
            end
            checks++;
            if ({a_if.rvalid, b_if.rvalid} !== {era[e], erb[e]}) begin
                errors++;
                $display("FAIL rnd_rvalid[%0d]: got %b want %b", e,
                         {a_if.rvalid, b_if.rvalid}, {era[e], erb[e]});
            end
            checks++;
            if ({a_if.rdata, b_if.rdata} !== {hold_a, hold_b}) begin
                errors++;
                $display("FAIL rnd_rdata[%0d]: got %h %h want %h %h", e,
                         a_if.rdata, b_if.rdata, hold_a, hold_b);
            end
            was_req = a_if.req;
            if (ega[e] || (a_if.req && $urandom_range(7) == 0)) a_if.req = 1'b0;
            if (!was_req && $urandom_range(1) == 1) begin
                a_if.req = 1'b1; a_if.we = 1'($urandom);
                a_if.addr = ADDR_W'($urandom_range(3)); a_if.wdata = DATA_W'($urandom);
            end
            was_req = b_if.req;
            if (egb[e] || (b_if.req && $urandom_range(7) == 0)) b_if.req = 1'b0;
            if (!was_req && $urandom_range(1) == 1) begin
                b_if.req = 1'b1; b_if.we = 1'($urandom);
                b_if.addr = ADDR_W'($urandom_range(3)); b_if.wdata = DATA_W'($urandom);
            end
        end
        idle_inputs();
        step();
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got no completion want finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_reset_mid_access();
        test_write_read();
        test_simultaneous();
        test_contention();
        test_hazard();
`ifdef ARB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
